mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data read/write port of the Memory block between two requesters:
  - the CPU load/store unit (cpu_*);
  - the program loader/debug unit (ldr_*), which fills instruction/data memory over serial.
- Uses a req/ack handshake. Each granted access drives address, data, writeMode, readMode and unsignedLoad onto Memory for exactly one cycle, then returns registered read data with ack.
- An optional lock lets one requester keep the port for back-to-back accesses; a bounded watchdog limits how long it can keep it.
- The PC fetch port is untouched.

Parameters:
- LOCK_MAX, 16, max consecutive HOLD cycles before a lock is forcibly released (>=1).
- CNT_W, 5, lock counter width; must satisfy 2**CNT_W > LOCK_MAX.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- cpu_req, ldr_req  input  1  access request; held until ack
- cpu_lock, ldr_lock  input  1  keep grant after this access
- cpu_address, ldr_address  input  32  byte address
- cpu_data, ldr_data  input  32  store data
- cpu_writeMode, ldr_writeMode  input  3  memory mode enum (NONE/WORD/HALFWORD/BYTE/WORDLEFT/WORDRIGHT)
- cpu_readMode, ldr_readMode  input  3  memory mode enum
- cpu_unsignedLoad, ldr_unsignedLoad  input  1  zero-extend load
- cpu_ack, ldr_ack  output  1  one-cycle completion pulse
- cpu_rdata, ldr_rdata  output  32  read data, valid while ack high
- mem_address, mem_data  output  32  to Memory
- mem_writeMode, mem_readMode  output  3  to Memory
- mem_unsignedLoad  output  1  to Memory
- mem_dataOutput  input  32  from Memory (combinational read)
- owner  output  2  00 none, 01 cpu, 10 ldr
- lock_expired  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset:
  - state IDLE, owner 00, counter 0.
  - All ack/rdata/lock_expired are 0.
  - mem_* are 0 with both modes NONE.
  - An access in ISSUE when rst falls is aborted: no write commits, no ack.
- Only in ISSUE do mem_* carry the owner's fields (combinational mux on registered owner). In all other states both modes are NONE and address/data are 0.
- States and transitions:
  - IDLE: if any req, choose owner (arbitration below) -> ISSUE.
  - ISSUE: Memory performs the access; the write commits at this cycle's closing edge; rdata_reg captures mem_dataOutput -> DONE.
  - DONE: owner's ack=1 and rdata=rdata_reg.
    - Owner lock=1 -> HOLD, counter cleared.
    - Otherwise -> IDLE, owner 00.
  - HOLD: port reserved, counter increments each cycle.
    - Owner req=1 -> ISSUE, same owner, no re-arbitration.
    - Owner lock=0 -> IDLE.
    - Counter reaches LOCK_MAX -> IDLE, lock_expired pulse.
    - Priority order: req, then lock drop, then expiry.
- Latency: req sampled high in IDLE at cycle N -> ack at N+2. Locked back-to-back throughput is 1 access per 3 cycles.
- Arbitration (fixed): cpu wins over ldr when both are requesting in IDLE.
- Requester rules:
  - Fields must stay stable while req is high.
  - req is dropped, or changed to the next access, in the cycle after ack.
  - The arbiter ignores req during DONE.
- Both modes NONE is still a legal access: it completes with ack, and rdata is whatever Memory returns.
- Both modes non-NONE: both are passed through unchanged.
- The non-owner's ack stays 0 and its rdata holds its last value.
- Lock asserted with req low in IDLE has no effect.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: a last-served flag (reset = ldr) flips on each ack. When both request in IDLE, the requester not last served wins.
- Undefined: fixed cpu priority as above; no last-served flag exists.

Decomposition:
- Add arb_state_t (IDLE, ISSUE, DONE, HOLD) and owner_t (OWN_NONE, OWN_CPU, OWN_LDR) to a shared package.
- The mode enum comes from MemoryModesPackage; no duplication.
- One sub-module is natural: mem_arb_lock_timer.
  - Counter with clear, enable and expire output.
  - Parameterised by LOCK_MAX and CNT_W.

Test Plan:
- Single CPU store then load: cpu WORD write 0x22345678 @65532, then WORD read @65532 -> cpu_ack 2 cycles after each req; cpu_rdata=0x22345678; ldr_ack stays 0.
- Simultaneous req, fixed priority: cpu read @65528 and ldr WORD write 0xA1B2C3D4 @65528 in the same cycle -> cpu served first with old data 0x0; ldr ack 3 cycles later; subsequent read returns 0xA1B2C3D4. Under MEM_ARB_ROUND_ROBIN_EN, the second collision goes to ldr.
- Lock burst: ldr lock=1 with 4 BYTE writes B2@65530, D4@65528, A1@65531, C3@65529 -> owner stays 10 throughout; a cpu req meanwhile gets no ack until the lock drops; word read = 0xA1B2C3D4.
- Watchdog: ldr lock=1, req=0 for >LOCK_MAX cycles with cpu_req pending -> lock_expired pulse after exactly 16 HOLD cycles; cpu ack 2 cycles later.
- Reset mid-access: assert rst during ISSUE of cpu WORD write 0x12345678 @65528 (prior value 0) -> no ack; mem modes NONE immediately; post-reset read returns 0x0.
- Signed/partial pass-through: cpu HALFWORD read @65528 with word 0x0000FFFF, unsignedLoad 0 then 1 -> rdata 0xFFFFFFFF then 0x0000FFFF.

Source files
------------

// File: rtl/MemoryModesPackage.sv
// Memory access mode encoding shared by the Memory block and its clients.
//   NONE      : no access in this direction
//   WORD      : 32-bit access
//   HALFWORD  : 16-bit access, lane selected by address[1]
//   BYTE      : 8-bit access, lane selected by address[1:0]
//   WORDLEFT  : unaligned-word left part
//   WORDRIGHT : unaligned-word right part
package MemoryModesPackage;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    WORD      = 3'd1,
    HALFWORD  = 3'd2,
    BYTE      = 3'd3,
    WORDLEFT  = 3'd4,
    WORDRIGHT = 3'd5
  } memory_mode_t;

endpackage

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state, port owner encoding, the bundle of
// per-requester memory fields and the arbitration helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10,
    HOLD  = 2'b11
  } arb_state_t;

  // Encoding is visible on the owner output: 00 none, 01 cpu, 10 ldr.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LDR  = 2'b10
  } owner_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [2:0]  write_mode;
    logic [2:0]  read_mode;
    logic        unsigned_load;
  } mem_fields_t;

  // cpu wins a collision unless prefer_ldr is set (round-robin turn).
  function automatic owner_t pick_owner(input logic cpu_req, input logic ldr_req,
                                        input logic prefer_ldr);
    if (cpu_req && !(ldr_req && prefer_ldr)) begin
      return OWN_CPU;
    end else if (ldr_req) begin
      return OWN_LDR;
    end
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_lock_timer.sv
// Lock watchdog counter for mem_port_arbiter.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clr_i     : clear the count (wins over en_i)
//   en_i      : count one HOLD cycle
//   expired_o : high during the HOLD cycle that makes the LOCK_MAX-th count
// LOCK_MAX must be >= 1 and 2**CNT_W must exceed LOCK_MAX.
module mem_arb_lock_timer #(
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LOCK_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Expire on the cycle whose increment would reach LOCK_MAX, so the lock
  // holds for exactly LOCK_MAX HOLD cycles.
  assign expired_o = en_i && !clr_i && (cnt_q == LastCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the Memory data port between the CPU load/store unit (cpu_*) and the
// program loader/debug unit (ldr_*). Each grant drives one access onto mem_* for a
// single ISSUE cycle, captures mem_dataOutput, and pulses the owner's ack with the
// registered read data in the following DONE cycle. A requester holding lock keeps
// the port (HOLD) for back-to-back accesses, bounded by a LOCK_MAX-cycle watchdog.
//
// Ports:
//   clk, rst                 : clock (rising edge), asynchronous active-low reset
//   cpu_*/ldr_* req, lock    : request (held until ack), keep grant after access
//   cpu_*/ldr_* fields       : address, data, writeMode, readMode, unsignedLoad
//   cpu_ack/ldr_ack          : one-cycle completion pulse
//   cpu_rdata/ldr_rdata      : read data, valid with ack, held otherwise
//   mem_*                    : access fields to Memory, idle (modes NONE) outside ISSUE
//   mem_dataOutput           : combinational read data from Memory
//   owner                    : 00 none, 01 cpu, 10 ldr
//   lock_expired             : one-cycle pulse after a watchdog release
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate collision winners using a
// last-served flag; otherwise cpu always wins a collision.
module mem_port_arbiter
  import MemoryModesPackage::*;
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        ldr_req,
  input  logic        cpu_lock,
  input  logic        ldr_lock,
  input  logic [31:0] cpu_address,
  input  logic [31:0] ldr_address,
  input  logic [31:0] cpu_data,
  input  logic [31:0] ldr_data,
  input  logic [2:0]  cpu_writeMode,
  input  logic [2:0]  ldr_writeMode,
  input  logic [2:0]  cpu_readMode,
  input  logic [2:0]  ldr_readMode,
  input  logic        cpu_unsignedLoad,
  input  logic        ldr_unsignedLoad,
  output logic        cpu_ack,
  output logic        ldr_ack,
  output logic [31:0] cpu_rdata,
  output logic [31:0] ldr_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic [2:0]  mem_writeMode,
  output logic [2:0]  mem_readMode,
  output logic        mem_unsignedLoad,
  input  logic [31:0] mem_dataOutput,
  output logic [1:0]  owner,
  output logic        lock_expired
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] ldr_rdata_q, ldr_rdata_d;
  logic        lock_expired_q, lock_expired_d;

  logic        owner_req, owner_lock;
  logic        timer_clr, timer_en, timer_expired;
  logic        prefer_ldr;
  mem_fields_t cpu_fields, ldr_fields;

  assign cpu_fields = '{address: cpu_address, data: cpu_data, write_mode: cpu_writeMode,
                        read_mode: cpu_readMode, unsigned_load: cpu_unsignedLoad};
  assign ldr_fields = '{address: ldr_address, data: ldr_data, write_mode: ldr_writeMode,
                        read_mode: ldr_readMode, unsigned_load: ldr_unsignedLoad};

  // Requests and lock of the current owner only; the other side is ignored while
  // the port is held.
  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    unique case (owner_q)
      OWN_CPU: begin
        owner_req  = cpu_req;
        owner_lock = cpu_lock;
      end
      OWN_LDR: begin
        owner_req  = ldr_req;
        owner_lock = ldr_lock;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // High when ldr was served last; reset value favours cpu on the first collision.
  logic last_ldr_q, last_ldr_d;

  assign prefer_ldr = !last_ldr_q;

  always_comb begin
    last_ldr_d = last_ldr_q;
    if (state_q == DONE) begin
      last_ldr_d = (owner_q == OWN_LDR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ldr_q <= 1'b1;
    end else begin
      last_ldr_q <= last_ldr_d;
    end
  end
`else
  assign prefer_ldr = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cpu_rdata_d    = cpu_rdata_q;
    ldr_rdata_d    = ldr_rdata_q;
    lock_expired_d = 1'b0;
    timer_clr      = 1'b0;
    timer_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        owner_d = pick_owner(cpu_req, ldr_req, prefer_ldr);
        if (owner_d != OWN_NONE) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = mem_dataOutput;
        end else if (owner_q == OWN_LDR) begin
          ldr_rdata_d = mem_dataOutput;
        end
        state_d = DONE;
      end
      DONE: begin
        if (owner_lock) begin
          state_d   = HOLD;
          timer_clr = 1'b1;
        end else begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      HOLD: begin
        timer_en = 1'b1;
        if (owner_req) begin
          state_d = ISSUE;
        end else if (!owner_lock) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end else if (timer_expired) begin
          state_d        = IDLE;
          owner_d        = OWN_NONE;
          lock_expired_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  mem_arb_lock_timer #(
    .LOCK_MAX (LOCK_MAX),
    .CNT_W    (CNT_W)
  ) u_lock_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // Decoded from registered state so an asynchronous reset idles Memory at once and
  // an in-flight write never reaches its commit edge.
  always_comb begin
    mem_address      = '0;
    mem_data         = '0;
    mem_writeMode    = NONE;
    mem_readMode     = NONE;
    mem_unsignedLoad = 1'b0;
    if (state_q == ISSUE) begin
      unique case (owner_q)
        OWN_CPU: begin
          mem_address      = cpu_fields.address;
          mem_data         = cpu_fields.data;
          mem_writeMode    = cpu_fields.write_mode;
          mem_readMode     = cpu_fields.read_mode;
          mem_unsignedLoad = cpu_fields.unsigned_load;
        end
        OWN_LDR: begin
          mem_address      = ldr_fields.address;
          mem_data         = ldr_fields.data;
          mem_writeMode    = ldr_fields.write_mode;
          mem_readMode     = ldr_fields.read_mode;
          mem_unsignedLoad = ldr_fields.unsigned_load;
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack      = (state_q == DONE) && (owner_q == OWN_CPU);
  assign ldr_ack      = (state_q == DONE) && (owner_q == OWN_LDR);
  assign cpu_rdata    = cpu_rdata_q;
  assign ldr_rdata    = ldr_rdata_q;
  assign owner        = owner_q;
  assign lock_expired = lock_expired_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      cpu_rdata_q    <= '0;
      ldr_rdata_q    <= '0;
      lock_expired_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cpu_rdata_q    <= cpu_rdata_d;
      ldr_rdata_q    <= ldr_rdata_d;
      lock_expired_q <= lock_expired_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a small behavioural Memory model.
module tb_mem_port_arbiter;
  import MemoryModesPackage::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, ldr_req, cpu_lock, ldr_lock;
  logic [31:0] cpu_address, ldr_address, cpu_data, ldr_data;
  logic [2:0]  cpu_writeMode, ldr_writeMode, cpu_readMode, ldr_readMode;
  logic        cpu_unsignedLoad, ldr_unsignedLoad;
  logic        cpu_ack, ldr_ack;
  logic [31:0] cpu_rdata, ldr_rdata;
  logic [31:0] mem_address, mem_data, mem_dataOutput;
  logic [2:0]  mem_writeMode, mem_readMode;
  logic        mem_unsignedLoad;
  logic [1:0]  owner;
  logic        lock_expired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .ldr_req(ldr_req), .cpu_lock(cpu_lock), .ldr_lock(ldr_lock),
    .cpu_address(cpu_address), .ldr_address(ldr_address),
    .cpu_data(cpu_data), .ldr_data(ldr_data),
    .cpu_writeMode(cpu_writeMode), .ldr_writeMode(ldr_writeMode),
    .cpu_readMode(cpu_readMode), .ldr_readMode(ldr_readMode),
    .cpu_unsignedLoad(cpu_unsignedLoad), .ldr_unsignedLoad(ldr_unsignedLoad),
    .cpu_ack(cpu_ack), .ldr_ack(ldr_ack), .cpu_rdata(cpu_rdata), .ldr_rdata(ldr_rdata),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_writeMode(mem_writeMode), .mem_readMode(mem_readMode),
    .mem_unsignedLoad(mem_unsignedLoad), .mem_dataOutput(mem_dataOutput),
    .owner(owner), .lock_expired(lock_expired)
  );

  // ---------------- Memory model (little-endian, 64 words, addr[7:2]) ----------------
  logic [31:0] mem_words [0:63];
  logic        mem_clr;

  function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] rm, input logic uns);
    logic [15:0] h;
    logic [7:0]  b;
    h = lane[1] ? w[31:16] : w[15:0];
    b = w[8*lane +: 8];
    if (rm == HALFWORD) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    if (rm == BYTE)     return uns ? {24'h0, b} : {{24{b[7]}}, b};
    return w;
  endfunction

  always_comb mem_dataOutput = mem_read(mem_words[mem_address[7:2]], mem_address[1:0],
                                        mem_readMode, mem_unsignedLoad);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_words[i] <= '0;
    end else if (mem_writeMode == HALFWORD) begin
      mem_words[mem_address[7:2]][16*mem_address[1] +: 16] <= mem_data[15:0];
    end else if (mem_writeMode == BYTE) begin
      mem_words[mem_address[7:2]][8*mem_address[1:0] +: 8] <= mem_data[7:0];
    end else if (mem_writeMode != NONE) begin
      mem_words[mem_address[7:2]] <= mem_data;
    end
  end

  // ---------------- Checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: {check_rdata, expected rdata}, pushed on drive, popped on ack.
  logic [32:0] cpu_q[$];
  logic [32:0] ldr_q[$];

  always @(negedge clk) begin
    if (rst && cpu_ack) begin
      if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 32'd1, 32'd0);
      else begin
        if (cpu_q[0][32]) chk("cpu_rdata", cpu_rdata, cpu_q[0][31:0]);
        cpu_q.delete(0);
      end
    end
    if (rst && ldr_ack) begin
      if (ldr_q.size() == 0) chk("ldr_unexpected_ack", 32'd1, 32'd0);
      else begin
        if (ldr_q[0][32]) chk("ldr_rdata", ldr_rdata, ldr_q[0][31:0]);
        ldr_q.delete(0);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  wm;
    logic [2:0]  rm;
    logic        uns;
    logic        chk;
    logic [31:0] exp_rdata;
    int          exp_at;
  } acc_t;

  typedef struct {
    acc_t cpu;
    acc_t ldr;
  } vec_t;

  function automatic acc_t mk(input logic en, input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] wm, input logic [2:0] rm, input logic uns,
                              input logic c, input logic [31:0] exp, input int at);
    acc_t a;
    a.en = en; a.addr = addr; a.data = data; a.wm = wm; a.rm = rm; a.uns = uns;
    a.chk = c; a.exp_rdata = exp; a.exp_at = at;
    return a;
  endfunction

  task automatic drive_cpu(input acc_t a);
    cpu_req = 1'b1; cpu_address = a.addr; cpu_data = a.data;
    cpu_writeMode = a.wm; cpu_readMode = a.rm; cpu_unsignedLoad = a.uns;
    cpu_q.push_back({a.chk, a.exp_rdata});
  endtask

  task automatic drive_ldr(input acc_t a);
    ldr_req = 1'b1; ldr_address = a.addr; ldr_data = a.data;
    ldr_writeMode = a.wm; ldr_readMode = a.rm; ldr_unsignedLoad = a.uns;
    ldr_q.push_back({a.chk, a.exp_rdata});
  endtask

  // Cycle 1 is the cycle in which req is first driven; ack is expected in cycle exp_at.
  task automatic run_vec(input vec_t v, input int idx);
    int cpu_at = 0;
    int ldr_at = 0;
    @(posedge clk); #1;
    if (v.cpu.en) drive_cpu(v.cpu);
    if (v.ldr.en) drive_ldr(v.ldr);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cpu_ack && cpu_at == 0) cpu_at = c;
      if (ldr_ack && ldr_at == 0) ldr_at = c;
      @(posedge clk); #1;
      if (cpu_at != 0) cpu_req = 1'b0;
      if (ldr_at != 0) ldr_req = 1'b0;
      if ((!v.cpu.en || cpu_at != 0) && (!v.ldr.en || ldr_at != 0)) break;
    end
    if (v.cpu.en) chk($sformatf("vec%0d_cpu_ack_cycle", idx), cpu_at, v.cpu.exp_at);
    if (v.ldr.en) chk($sformatf("vec%0d_ldr_ack_cycle", idx), ldr_at, v.ldr.exp_at);
  endtask

  localparam logic [31:0] A28 = 32'd65528;
  localparam logic [31:0] A32 = 32'd65532;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    acc_t none;
    none = mk(1'b0, '0, '0, NONE, NONE, 1'b0, 1'b0, '0, 0);
    vecs[0] = '{cpu: mk(1, A32, 32'h22345678, WORD, NONE, 0, 0, 0, 3), ldr: none};
    vecs[1] = '{cpu: mk(1, A32, 0, NONE, WORD, 0, 1, 32'h22345678, 3), ldr: none};
    vecs[2] = '{cpu: mk(1, A28, 0, NONE, WORD, 0, 1, 32'h0, 3),
                ldr: mk(1, A28, 32'hA1B2C3D4, WORD, NONE, 0, 0, 0, 6)};
    vecs[3] = '{cpu: mk(1, A28, 0, NONE, WORD, 0, 1, 32'hA1B2C3D4, 3), ldr: none};
    vecs[4] = '{cpu: mk(1, A28, 32'h0000FFFF, WORD, NONE, 0, 0, 0, 3), ldr: none};
    vecs[5] = '{cpu: mk(1, A28, 0, NONE, HALFWORD, 0, 1, 32'hFFFFFFFF, 3), ldr: none};
    vecs[6] = '{cpu: mk(1, A28, 0, NONE, HALFWORD, 1, 1, 32'h0000FFFF, 3), ldr: none};
    vecs[7] = '{cpu: none, ldr: mk(1, A28, 0, NONE, BYTE, 0, 1, 32'hFFFFFFFF, 3)};

    rst = 1'b0; mem_clr = 1'b1;
    cpu_req = 0; ldr_req = 0; cpu_lock = 0; ldr_lock = 0;
    cpu_address = 0; ldr_address = 0; cpu_data = 0; ldr_data = 0;
    cpu_writeMode = NONE; ldr_writeMode = NONE; cpu_readMode = NONE; ldr_readMode = NONE;
    cpu_unsignedLoad = 0; ldr_unsignedLoad = 0;

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_owner", owner, 2'b00);
    chk("rst_acks", {cpu_ack, ldr_ack, lock_expired}, 3'b000);
    chk("rst_rdata", cpu_rdata | ldr_rdata, 32'h0);
    chk("rst_mem_modes", {mem_writeMode, mem_readMode}, {NONE, NONE});
    chk("rst_mem_addr_data", mem_address | mem_data, 32'h0);
    mem_clr = 1'b0; rst = 1'b1;

    // ---- Lock with no request in IDLE does nothing ----
    @(posedge clk); #1; cpu_lock = 1'b1;
    repeat (3) @(posedge clk);
    #1; chk("idle_lock_owner", owner, 2'b00);
    cpu_lock = 1'b0;

    // ---- Reset during ISSUE aborts the write ----
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_address = A28; cpu_data = 32'h12345678;
    cpu_writeMode = WORD; cpu_readMode = NONE;
    @(posedge clk); #2;
    chk("abort_issue_wmode", mem_writeMode, WORD);
    rst = 1'b0; #1;
    chk("abort_wmode_none", mem_writeMode, NONE);
    chk("abort_owner", owner, 2'b00);
    @(negedge clk); chk("abort_no_ack", cpu_ack, 1'b0);
    @(posedge clk); #1; cpu_req = 1'b0; cpu_writeMode = NONE;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    repeat (2) @(posedge clk);

    // ---- Table-driven accesses ----
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // ---- Locked ldr byte burst with a cpu read waiting ----
    begin
      logic [31:0] baddr [4];
      logic [31:0] bdata [4];
      int ack_c [4];
      int k = 0;
      int cpu_at = 0;
      logic owner_ok = 1'b1;
      logic ack_now;
      baddr = '{32'd65530, 32'd65528, 32'd65531, 32'd65529};
      bdata = '{32'hB2, 32'hD4, 32'hA1, 32'hC3};
      ack_c = '{0, 0, 0, 0};
      @(posedge clk); #1;
      ldr_lock = 1'b1;
      drive_ldr(mk(1, baddr[0], bdata[0], BYTE, NONE, 0, 0, 0, 0));
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (c >= 2 && k < 4 && owner != 2'b10) owner_ok = 1'b0;
        ack_now = ldr_ack;
        if (ldr_ack && k < 4) begin ack_c[k] = c; k++; end
        if (cpu_ack && cpu_at == 0) cpu_at = c;
        @(posedge clk); #1;
        if (c == 1) drive_cpu(mk(1, A28, 0, NONE, WORD, 0, 1, 32'hA1B2C3D4, 0));
        if (ack_now) begin
          if (k < 4) drive_ldr(mk(1, baddr[k], bdata[k], BYTE, NONE, 0, 0, 0, 0));
          else begin ldr_req = 1'b0; ldr_lock = 1'b0; end
        end
        if (cpu_at != 0) begin cpu_req = 1'b0; break; end
      end
      for (int j = 0; j < 4; j++) chk($sformatf("burst_ack%0d_cycle", j), ack_c[j], 3*j + 3);
      chk("burst_owner_held", owner_ok, 1'b1);
      chk("burst_cpu_ack_cycle", cpu_at, 16);
    end

    // ---- Watchdog releases an idle lock ----
    begin
      int ldr_at = 0;
      int exp_at = 0;
      int exp_cnt = 0;
      int cpu_at = 0;
      @(posedge clk); #1;
      ldr_lock = 1'b1;
      drive_ldr(mk(1, A32, 0, NONE, WORD, 0, 1, 32'h22345678, 0));
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (ldr_ack && ldr_at == 0) ldr_at = c;
        if (lock_expired) begin exp_cnt++; if (exp_at == 0) exp_at = c; end
        if (cpu_ack && cpu_at == 0) cpu_at = c;
        @(posedge clk); #1;
        if (ldr_at != 0 && c == ldr_at) begin
          ldr_req = 1'b0;
          drive_cpu(mk(1, A32, 0, NONE, WORD, 0, 1, 32'h22345678, 0));
        end
        if (cpu_at != 0) begin cpu_req = 1'b0; ldr_lock = 1'b0; break; end
      end
      chk("wdog_ldr_ack_cycle", ldr_at, 3);
      chk("wdog_expired_cycle", exp_at, 20);
      chk("wdog_expired_pulses", exp_cnt, 1);
      chk("wdog_cpu_ack_cycle", cpu_at, 22);
    end

    repeat (3) @(posedge clk);
    chk("cpu_scoreboard_drained", cpu_q.size(), 0);
    chk("ldr_scoreboard_drained", ldr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
